// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_INC    = 32'h0000_0004;

endpackage

// File: rtl/fetch_controller_buffer.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode.
module fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_instr_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        last_o,
    output logic [31:0] head_pc_o,
    output logic [31:0] head_instr_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign last_o  = (cnt_q == CW'(1));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot this cycle, so a full buffer can still accept.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            pc_mem_q[wptr_q]    <= push_pc_i;
            instr_mem_q[wptr_q] <= push_instr_i;
        end
    end

    // Storage is not reset; gating on empty keeps the head at zero instead.
    assign head_pc_o    = empty_o ? 32'h0 : pc_mem_q[rptr_q];
    assign head_instr_o = empty_o ? 32'h0 : instr_mem_q[rptr_q];

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: walks fetch_pc through instruction memory, handles redirects and halting.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          MEM_BYTES = 109,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err
);
    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         misalign_q, misalign_d;
    logic         push, flush, pop;
    logic         buf_full, buf_empty, buf_last;
    logic [32:0]  word_end;
    logic         at_end;

    // Widened so a fetch_pc near 2^32 cannot wrap past the bound check.
    assign word_end = {1'b0, fetch_pc_q} + 33'd3;
    assign at_end   = (word_end > 33'(MEM_BYTES - 1));
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (redirect_valid) begin
            flush = 1'b1;
            if (redirect_pc[1:0] == 2'b00) begin
                fetch_pc_d = redirect_pc;
                state_d    = ST_RUN;
            end else begin
                misalign_d = 1'b1;
                state_d    = ST_HALT;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (at_end) begin
                        state_d = ST_DRAIN;
                    end else if (!buf_full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + FETCH_INC;
                    end
                end
                ST_DRAIN: begin
                    if (buf_empty || (buf_last && pop)) state_d = ST_HALT;
                end
                default: ;
            endcase
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .flush_i      (flush),
        .full_o       (buf_full),
        .empty_o      (buf_empty),
        .last_o       (buf_last),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr)
    );

    assign imem_addr    = fetch_pc_q;
    assign out_valid    = !buf_empty;
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a combinational instruction memory model.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_instr, out_pc;
    logic        halted, misalign_err;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h00940333;
            32'h04: return 32'h800100b3;
            32'h08: return 32'h00209133;
            32'h50: return 32'h0041a463;
            default: return {12'hABC, a[19:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_range(input logic [31:0] lo, input logic [31:0] hi);
        for (logic [31:0] a = lo; a <= hi; a += 32'h4)
            exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic wait_halted(input string nm, input int max);
        for (int i = 0; i < max && !halted; i++) tick();
        chk(nm, {31'b0, halted}, 32'h1);
    endtask

    task automatic wait_pc(input string nm, input logic [31:0] pc, input int max);
        for (int i = 0; i < max && !(out_valid && out_pc == pc); i++) tick();
        chk(nm, out_pc, pc);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got pc %h instr %h expected nothing", out_pc, out_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e[63:32]);
                chk("sb_instr", out_instr, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        tick();

        // Streaming from reset; a redirect during BOOT must be ignored
        expect_range(32'h0, 32'h68);
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h50;
        tick();
        redirect_valid = 1'b0;
        chk("boot_no_valid", {31'b0, out_valid}, 32'h0);
        tick();
        chk("first_valid", {31'b0, out_valid}, 32'h1);
        chk("first_pc", out_pc, 32'h0);
        wait_halted("halt_at_end", 60);
        chk("halt_empty", {31'b0, out_valid}, 32'h0);
        chk("stream_drained", exp_q.size(), 32'h0);

        // Resume from halt, then redirect to 0x50 while 0x8 is at the head
        expect_range(32'h0, 32'h8);
        expect_range(32'h50, 32'h68);
        redirect(32'h0);
        chk("resume_halted", {31'b0, halted}, 32'h0);
        wait_pc("head_is_8", 32'h8, 20);
        redirect(32'h50);
        chk("flush_empty", {31'b0, out_valid}, 32'h0);
        wait_halted("halt_after_50", 40);
        chk("redirect_drained", exp_q.size(), 32'h0);

        // Back-pressure right after the first push
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        out_ready = 1'b0;
        reset = 1'b0;
        expect_range(32'h0, 32'h68);
        tick();
        tick();
        chk("bp_first_valid", {31'b0, out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pc_stable", out_pc, 32'h0);
            chk("bp_instr_stable", out_instr, 32'h00940333);
            chk("bp_imem_addr", imem_addr, 32'h8);
        end
        out_ready = 1'b1;
        wait_pc("bp_reach_10", 32'h10, 20);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_pc", out_pc, 32'h0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        expect_range(32'h0, 32'h68);
        wait_pc("post_rst_reach_10", 32'h10, 20);

        // Misaligned redirect halts and sets the sticky error
        out_ready = 1'b0;
        tick();
        exp_q.delete();
        redirect(32'h22);
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        chk("mis_halted", {31'b0, halted}, 32'h1);
        chk("mis_valid", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mis_still_halted", {31'b0, halted}, 32'h1);
        expect_range(32'h60, 32'h68);
        redirect(32'h60);
        wait_halted("halt_after_60", 30);
        chk("mis_sticky", {31'b0, misalign_err}, 32'h1);
        chk("tail_drained", exp_q.size(), 32'h0);

        reset = 1'b1;
        #1;
        chk("mis_cleared", {31'b0, misalign_err}, 32'h0);
        chk("rst_halted_clr", {31'b0, halted}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
